// File: rtl/plab4_net_router_domain_sched_pkg.sv
// Shared plab4_net constants used by the router domain scheduler.
// Domain and scheduling-mode encodings.
package plab4_net_router_domain_sched_pkg;

    localparam logic DOM_D1 = 1'b0;
    localparam logic DOM_D2 = 1'b1;

    localparam int MODE_RR  = 0;
    localparam int MODE_TDM = 1;

endpackage

// File: rtl/plab4_net_router_domain_sched.sv
// Router domain scheduler: picks which security domain drives the
// output-port requests and steers the returned grants back to it.
module plab4_net_router_domain_sched
    import plab4_net_router_domain_sched_pkg::*;
#(
    parameter int p_mode        = MODE_RR,
    parameter int p_slot_cycles = 4,
    parameter int c_cnt_nbits   = $clog2(p_slot_cycles)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] reqs_d1,
    input  logic [2:0] reqs_d2,
    output logic [2:0] reqs,
    input  logic [2:0] grants,
    output logic [2:0] grants_d1,
    output logic [2:0] grants_d2,
    output logic       domain
);

    logic w_dom;

    generate
        if (p_mode == MODE_TDM) begin : g_tdm
            localparam logic [c_cnt_nbits-1:0] CntLast =
                c_cnt_nbits'(p_slot_cycles - 1);

            logic                   r_owner;
            logic [c_cnt_nbits-1:0] r_cnt;

            // Slots rotate on a fixed schedule, independent of traffic.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_owner <= DOM_D1;
                    r_cnt   <= '0;
                end else if (r_cnt == CntLast) begin
                    r_owner <= ~r_owner;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
            end

            assign w_dom = r_owner;
        end else begin : g_rr
            logic r_prio;
            logic w_any1;
            logic w_any2;
            logic w_fire;

            assign w_any1 = |reqs_d1;
            assign w_any2 = |reqs_d2;
            assign w_fire = |(reqs & grants);

            always_comb begin
                w_dom = r_prio;
                unique case (1'b1)
                    (w_any1 && !w_any2): w_dom = DOM_D1;
                    (!w_any1 && w_any2): w_dom = DOM_D2;
                    default:             w_dom = r_prio;
                endcase
            end

            // Priority only moves on a completed handshake.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_prio <= DOM_D1;
                end else if (w_fire) begin
                    r_prio <= ~w_dom;
                end
            end
        end
    endgenerate

    assign domain    = reset ? DOM_D1 : w_dom;
    assign reqs      = reset ? 3'b000 :
                       (w_dom == DOM_D2) ? reqs_d2 : reqs_d1;
    assign grants_d1 = (reset || w_dom == DOM_D2) ? 3'b000 : grants;
    assign grants_d2 = (!reset && w_dom == DOM_D2) ? grants : 3'b000;

endmodule

// File: doc/plab4_net_router_domain_sched.md
PLAB4_NET_ROUTER_DOMAIN_SCHED -- requirements
Module: plab4_net_RouterDomainSched

Interface
REQ-001 SHALL have parameter p_mode, default 0, selecting 0 = round-robin work-conserving, 1 = fixed time-division slots.
REQ-002 SHALL have parameter p_slot_cycles, default 4, giving the slot length in cycles for mode 1; legal range 2..256.
REQ-003 SHALL have parameter c_cnt_nbits, default $clog2(p_slot_cycles), giving the slot counter width; not set externally.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port reqs_d1, input, 3 bits: domain-1 input-ctrl output-port requests {p2,p1,p0}.
REQ-007 SHALL have port reqs_d2, input, 3 bits: domain-2 input-ctrl output-port requests {p2,p1,p0}.
REQ-008 SHALL have port reqs, output, 3 bits: requests forwarded to the output-port arbiters.
REQ-009 SHALL have port grants, input, 3 bits: grants returned by the output-port arbiters.
REQ-010 SHALL have port grants_d1, output, 3 bits: grants steered to domain 1.
REQ-011 SHALL have port grants_d2, output, 3 bits: grants steered to domain 2.
REQ-012 SHALL have port domain, output, 1 bit: domain currently owning reqs/grants (0 = D1, 1 = D2).

Function
REQ-013 SHALL be fully combinational from inputs and state to outputs, with zero latency and no inferred latches; every output is assigned on every path.
REQ-014 SHALL steer grants as follows: domain==0 gives grants_d1=grants and grants_d2=0; domain==1 gives grants_d2=grants and grants_d1=0.
REQ-015 SHALL define fire = |(reqs & grants), the handshake completing this cycle.
REQ-016 SHALL, in mode 0, keep a 1-bit priority register prio.
REQ-017 SHALL, in mode 0, select the domain as follows:
- only D1 requesting: domain=0
- only D2 requesting: domain=1
- both requesting: domain=prio
- neither requesting: domain=prio, reqs=0
REQ-018 SHALL, in mode 0, set prio to ~domain on the next edge when fire=1, and hold prio when fire=0, so an ungranted request stays stable.
REQ-019 SHALL, in mode 1, keep an owner register and a slot counter cnt[c_cnt_nbits-1:0].
REQ-020 SHALL, in mode 1, drive domain=owner and reqs = owner's reqs; the non-owner's requests are blocked even while the owner is idle, so no timing dependence crosses domains.
REQ-021 SHALL, in mode 1, increment cnt every cycle; when cnt==p_slot_cycles-1, cnt wraps to 0 and owner toggles on the same edge, regardless of fire.
REQ-022 SHALL NOT let prio, owner or cnt depend on any random source.

Reset
REQ-023 SHALL, while reset is high, force prio=0, owner=0, cnt=0.
REQ-024 SHALL, while reset is high, drive reqs=0, grants_d1=0, grants_d2=0 and domain=0 irrespective of the request inputs.
REQ-025 SHALL resume after reset deassertion from the reset state: D1 has first priority, and in mode 1 the first slot is D1's, lasting p_slot_cycles.

Structure
REQ-026 SHALL take domain encodings (DOM_D1=0, DOM_D2=1) and mode encodings (MODE_RR=0, MODE_TDM=1) from the shared plab4_net constants package.
REQ-027 SHALL need no sub-module; the mode-1 logic is generated only when p_mode==1.

Verification
REQ-028 SHALL cover mode 0 with reqs_d1=001, reqs_d2=000 and grants=001: reqs=001, domain=0, grants_d1=001, grants_d2=000, prio becomes 1.
REQ-029 SHALL cover mode 0 with both domains requesting continuously (reqs_d1=010, reqs_d2=100) and grants=reqs every cycle: domain alternates 0,1,0,1 starting at 0 after reset.
REQ-030 SHALL cover mode 0 with both domains requesting and grants=000 for 5 cycles: domain and reqs are held constant, and prio does not change.
REQ-031 SHALL cover mode 1 (p_slot_cycles=4) with reqs_d1=000 and reqs_d2=001: reqs=000 for cycles 0-3 and reqs=001 for cycles 4-7, repeating.
REQ-032 SHALL cover reset asserted mid-slot (mode 1, cnt=2, owner=1) and mid-grant: outputs go to 0 immediately (asynchronously), and after release owner=0 and cnt=0.
